// File: rtl/gpio_irq_pkg.sv
// Shared constants for the Wishbone GPIO/IRQ bank: register word offsets
// (adr[7:2]) and the per-word valid-pin mask helper.
package gpio_irq_pkg;

    localparam int MAX_IO = 64;

    localparam logic [5:0] OFS_OUT_LO = 6'd0;
    localparam logic [5:0] OFS_OUT_HI = 6'd1;
    localparam logic [5:0] OFS_OEB_LO = 6'd2;
    localparam logic [5:0] OFS_OEB_HI = 6'd3;
    localparam logic [5:0] OFS_IN_LO  = 6'd4;
    localparam logic [5:0] OFS_IN_HI  = 6'd5;
    localparam logic [5:0] OFS_IE_LO  = 6'd6;
    localparam logic [5:0] OFS_IE_HI  = 6'd7;
    localparam logic [5:0] OFS_POL_LO = 6'd8;
    localparam logic [5:0] OFS_POL_HI = 6'd9;
    localparam logic [5:0] OFS_IS_LO  = 6'd10;
    localparam logic [5:0] OFS_IS_HI  = 6'd11;

    // Bits of the LO (pins 31:0) or HI (pins 63:32) word that map to real pads.
    function automatic logic [31:0] word_mask(input int num_io, input logic hi);
        int n;
        n = hi ? num_io - 32 : num_io;
        if (n <= 0) return 32'h0;
        if (n >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << n) - 32'h1;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// One pad input: two-flop synchroniser, history flop and a polarity-qualified
// single-cycle edge pulse (rising when pol=0, falling when pol=1).
module gpio_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    input  logic pol,
    output logic sync,
    output logic edge_pulse
);

    logic meta;
    logic hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
            hist <= sync;
        end
    end

    // Only a change of the synchronised level can fire; flipping pol alone cannot.
    assign edge_pulse = (sync & ~hist & ~pol) | (~sync & hist & pol);

endmodule

// File: rtl/wb_gpio_irq_bank.sv
// Wishbone classic GPIO bank: pad OUT/OEB registers, synchronised IN, per-pin
// edge status with enables, folded onto IRQ_LINES level interrupts.
module wb_gpio_irq_bank
    import gpio_irq_pkg::*;
#(
    parameter int          NUM_IO    = 38,
    parameter int          IRQ_LINES = 3,
    parameter logic [31:0] BASE_ADDR = 32'h3000_1000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic [31:0]          wbs_dat_o,
    output logic                 wbs_ack_o,
    input  logic [NUM_IO-1:0]    io_in,
    output logic [NUM_IO-1:0]    io_out,
    output logic [NUM_IO-1:0]    io_oeb,
    output logic [IRQ_LINES-1:0] user_irq
);

    localparam logic [31:0] MASK_LO   = word_mask(NUM_IO, 1'b0);
    localparam logic [31:0] MASK_HI   = word_mask(NUM_IO, 1'b1);
    localparam logic [63:0] FULL_MASK = {MASK_HI, MASK_LO};

    logic [63:0]          out_r, oeb_r, ie_r, pol_r, is_r;
    logic [63:0]          is_clr, is_next;
    logic [MAX_IO-1:0]    sync_w, evt_w;
    logic                 ack_r;
    logic [31:0]          dat_r, rdata, lane;
    logic [IRQ_LINES-1:0] irq_r, irq_next;
    logic                 sel_w, req, wr;
    logic [5:0]           ofs;
    logic                 unused_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [31:0] en, input logic [31:0] msk);
        return ((old & ~en) | (dat & en)) & msk;
    endfunction

    // A request is taken only while ack is low, so each access acks exactly once.
    assign sel_w = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req   = sel_w & ~ack_r;
    assign wr    = req & wbs_we_i;
    assign ofs   = wbs_adr_i[7:2];
    assign lane  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    for (genvar i = 0; i < MAX_IO; i++) begin : g_pin
        if (i < NUM_IO) begin : g_on
            gpio_sync_edge u_pin (
                .clk        (wb_clk_i),
                .rst_n      (wb_rst_ni),
                .pin        (io_in[i]),
                .pol        (pol_r[i]),
                .sync       (sync_w[i]),
                .edge_pulse (evt_w[i])
            );
        end else begin : g_off
            assign sync_w[i] = 1'b0;
            assign evt_w[i]  = 1'b0;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (ofs)
            OFS_OUT_LO: rdata = out_r[31:0];
            OFS_OUT_HI: rdata = out_r[63:32];
            OFS_OEB_LO: rdata = oeb_r[31:0];
            OFS_OEB_HI: rdata = oeb_r[63:32];
            OFS_IN_LO:  rdata = sync_w[31:0];
            OFS_IN_HI:  rdata = sync_w[63:32];
            OFS_IE_LO:  rdata = ie_r[31:0];
            OFS_IE_HI:  rdata = ie_r[63:32];
            OFS_POL_LO: rdata = pol_r[31:0];
            OFS_POL_HI: rdata = pol_r[63:32];
            OFS_IS_LO:  rdata = is_r[31:0];
            OFS_IS_HI:  rdata = is_r[63:32];
            default:    rdata = 32'h0;
        endcase
    end

    // New events are OR-ed in after the clear, so a same-cycle set survives W1C.
    always_comb begin
        is_clr = 64'h0;
        if (wr && ofs == OFS_IS_LO) is_clr[31:0]  = wbs_dat_i & lane;
        if (wr && ofs == OFS_IS_HI) is_clr[63:32] = wbs_dat_i & lane;
        is_next = ((is_r & ~is_clr) | evt_w) & FULL_MASK;
    end

    always_comb begin
        irq_next = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            irq_next[i % IRQ_LINES] = irq_next[i % IRQ_LINES] | (is_r[i] & ie_r[i]);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0;
            out_r <= 64'h0;
            oeb_r <= FULL_MASK;
            ie_r  <= 64'h0;
            pol_r <= 64'h0;
            is_r  <= 64'h0;
            irq_r <= '0;
        end else begin
            ack_r <= req;
            dat_r <= (req && !wbs_we_i) ? rdata : 32'h0;
            is_r  <= is_next;
            irq_r <= irq_next;
            if (wr) begin
                case (ofs)
                    OFS_OUT_LO: out_r[31:0]  <= merge(out_r[31:0],  wbs_dat_i, lane, MASK_LO);
                    OFS_OUT_HI: out_r[63:32] <= merge(out_r[63:32], wbs_dat_i, lane, MASK_HI);
                    OFS_OEB_LO: oeb_r[31:0]  <= merge(oeb_r[31:0],  wbs_dat_i, lane, MASK_LO);
                    OFS_OEB_HI: oeb_r[63:32] <= merge(oeb_r[63:32], wbs_dat_i, lane, MASK_HI);
                    OFS_IE_LO:  ie_r[31:0]   <= merge(ie_r[31:0],   wbs_dat_i, lane, MASK_LO);
                    OFS_IE_HI:  ie_r[63:32]  <= merge(ie_r[63:32],  wbs_dat_i, lane, MASK_HI);
                    OFS_POL_LO: pol_r[31:0]  <= merge(pol_r[31:0],  wbs_dat_i, lane, MASK_LO);
                    OFS_POL_HI: pol_r[63:32] <= merge(pol_r[63:32], wbs_dat_i, lane, MASK_HI);
                    default: ;
                endcase
            end
        end
    end

    assign wbs_ack_o   = ack_r;
    assign wbs_dat_o   = dat_r;
    assign io_out      = out_r[NUM_IO-1:0];
    assign io_oeb      = oeb_r[NUM_IO-1:0];
    assign user_irq    = irq_r;
    assign unused_bits = ^{wbs_adr_i[1:0], out_r, oeb_r, ie_r, pol_r, is_r};

endmodule

// File: tb/tb_wb_gpio_irq_bank.sv
// Directed plus randomised bench for wb_gpio_irq_bank against a pin-level
// behavioural model of the register bank and edge/IRQ rules.
module tb_wb_gpio_irq_bank;

    localparam int          NUM_IO    = 38;
    localparam int          IRQ_LINES = 3;
    localparam logic [31:0] BASE      = 32'h3000_1000;
    localparam logic [63:0] VMASK     = (64'h1 << NUM_IO) - 64'h1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cyc, stb, we;
    logic [3:0]           sel;
    logic [31:0]          adr, wdat;
    logic [31:0]          dat_o;
    logic                 ack;
    logic [NUM_IO-1:0]    io_in, io_out, io_oeb;
    logic [IRQ_LINES-1:0] user_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state, one bit per pin
    logic [63:0] m_out, m_oeb, m_ie, m_pol, m_is, m_pins;

    always #5 clk = ~clk;

    wb_gpio_irq_bank #(.NUM_IO(NUM_IO), .IRQ_LINES(IRQ_LINES), .BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_dat_o (dat_o),
        .wbs_ack_o (ack),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (user_irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_out = 64'h0; m_oeb = VMASK; m_ie = 64'h0; m_pol = 64'h0; m_is = 64'h0; m_pins = 64'h0;
    endtask

    task automatic model_write(input int ofs, input logic [31:0] d, input logic [3:0] s);
        int r, p;
        r = ofs / 2;
        for (int b = 0; b < 32; b++) begin
            p = (ofs % 2) * 32 + b;
            if (ofs < 12 && p < NUM_IO && s[b / 8]) begin
                case (r)
                    0: m_out[p] = d[b];
                    1: m_oeb[p] = d[b];
                    3: m_ie[p]  = d[b];
                    4: m_pol[p] = d[b];
                    5: if (d[b]) m_is[p] = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [31:0] model_read(input int ofs);
        logic [63:0] src;
        logic [31:0] v;
        int p;
        v = 32'h0;
        case (ofs / 2)
            0: src = m_out;
            1: src = m_oeb;
            2: src = m_pins;
            3: src = m_ie;
            4: src = m_pol;
            default: src = m_is;
        endcase
        for (int b = 0; b < 32; b++) begin
            p = (ofs % 2) * 32 + b;
            if (ofs < 12 && p < NUM_IO) v[b] = src[p];
        end
        return v;
    endfunction

    function automatic logic [IRQ_LINES-1:0] model_irq();
        logic [IRQ_LINES-1:0] v;
        v = '0;
        for (int p = 0; p < NUM_IO; p++) if (m_is[p] && m_ie[p]) v[p % IRQ_LINES] = 1'b1;
        return v;
    endfunction

    task automatic model_pins(input logic [63:0] nv);
        for (int p = 0; p < NUM_IO; p++) begin
            if (nv[p] && !m_pins[p] && !m_pol[p]) m_is[p] = 1'b1;
            if (!nv[p] && m_pins[p] && m_pol[p])  m_is[p] = 1'b1;
        end
        m_pins = nv & VMASK;
    endtask

    // ---------------- bus driver ----------------
    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0; rd = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i;
                rd  = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("dat_idle", {32'h0, dat_o}, 64'h0);
    endtask

    task automatic wb_write(input int ofs, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        wb_cycle(BASE | 32'(ofs * 4), 1'b1, d, s, rd, lat);
        check($sformatf("wr_lat_%0d", ofs), 64'(lat), 64'd1);
        if (lat == 1) model_write(ofs, d, s);
    endtask

    task automatic wb_read(input int ofs, output logic [31:0] rd);
        int lat;
        wb_cycle(BASE | 32'(ofs * 4), 1'b0, 32'h0, 4'hF, rd, lat);
        check($sformatf("rd_lat_%0d", ofs), 64'(lat), 64'd1);
    endtask

    task automatic read_check(input int ofs, input string tag);
        logic [31:0] rd;
        wb_read(ofs, rd);
        check(tag, {32'h0, rd}, {32'h0, model_read(ofs)});
    endtask

    task automatic check_pads(input string tag);
        check({tag, "_out"}, 64'(io_out), m_out & VMASK);
        check({tag, "_oeb"}, 64'(io_oeb), m_oeb & VMASK);
        check({tag, "_irq"}, 64'(user_irq), 64'(model_irq()));
    endtask

    task automatic set_pins(input logic [63:0] nv);
        @(negedge clk);
        io_in = nv[NUM_IO-1:0];
        model_pins(nv);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] nv;
        int lat, ofs;

        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        io_in = '0; rst_n = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dat", 64'(dat_o), 64'd0);
        check("rst_oeb", 64'(io_oeb), VMASK);
        check("rst_out", 64'(io_out), 64'd0);
        check("rst_irq", 64'(user_irq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int o = 0; o < 12; o++) begin
            wb_read(o, rd);
            check($sformatf("rst_reg_%0d", o), 64'(rd),
                  (o == 2) ? 64'hFFFF_FFFF : (o == 3) ? 64'h3F : 64'h0);
        end

        // Byte-lane write
        wb_write(0, 32'hA5A5_A5A5, 4'b0010);
        check("lane_out", 64'(io_out), 64'h0000_A500);
        read_check(0, "lane_rd");

        // Rising edge on pin 0 with exact IRQ latency
        wb_write(6, 32'h1, 4'hF);
        @(negedge clk);
        io_in[0] = 1'b1;
        model_pins(64'(io_in));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rise_irq_t%0d", k), 64'(user_irq[0]), (k == 4) ? 64'd1 : 64'd0);
        end
        wb_read(10, rd);
        check("rise_is", 64'(rd), 64'h1);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE | 32'h28; wdat = 32'h1; sel = 4'hF;
        @(posedge clk); #1;
        check("w1c_ack", 64'(ack), 64'd1);
        check("w1c_irq_c", 64'(user_irq[0]), 64'd1);
        cyc = 0; stb = 0; we = 0;
        model_write(10, 32'h1, 4'hF);
        @(posedge clk); #1;
        check("w1c_irq_c1", 64'(user_irq[0]), 64'd0);

        // Falling edge on pin 34
        nv = 64'(io_in); nv[34] = 1'b1;
        set_pins(nv);
        wb_write(11, 32'h4, 4'hF);
        wb_write(9, 32'h4, 4'hF);
        wb_write(7, 32'h4, 4'hF);
        nv[34] = 1'b0;
        set_pins(nv);
        check("fall_irq1", 64'(user_irq[1]), 64'd1);
        wb_read(11, rd);
        check("fall_is_hi", 64'(rd), 64'h4);
        wb_write(11, 32'h4, 4'hF);
        nv[34] = 1'b1;
        set_pins(nv);
        wb_read(11, rd);
        check("fall_rise_ignored", 64'(rd), 64'h0);
        check_pads("fall");

        // Set vs W1C race on pin 5
        nv[5] = 1'b1; set_pins(nv);
        nv[5] = 1'b0; set_pins(nv);
        @(negedge clk);
        io_in[5] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wb_write(10, 32'h20, 4'hF);
        model_pins(64'(io_in));
        wb_read(10, rd);
        check("race_is5", 64'(rd[5]), 64'd1);

        // Address handling
        wb_cycle(BASE + 32'h100, 1'b0, 32'h0, 4'hF, rd, lat);
        check("outside_noack", 64'(lat), 64'd0);
        wb_cycle(BASE + 32'h3C, 1'b0, 32'h0, 4'hF, rd, lat);
        check("unmapped_lat", 64'(lat), 64'd1);
        check("unmapped_dat", 64'(rd), 64'd0);
        wb_write(15, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'hFFFF_FFFF; sel = 4'hF;
        @(posedge clk); #1;
        check("no_cyc_noack", 64'(ack), 64'd0);
        stb = 1'b0; we = 1'b0;
        check_pads("addr");

        // Randomised register traffic
        for (int it = 0; it < 40; it++) begin
            ofs = $urandom_range(0, 15);
            wb_write(ofs, $urandom, 4'($urandom_range(0, 15)));
            check_pads($sformatf("rnd_wr%0d", it));
            read_check($urandom_range(0, 15), $sformatf("rnd_rd%0d", it));
        end

        // Randomised pin activity with random enables/polarity
        for (int it = 0; it < 20; it++) begin
            wb_write(8 + $urandom_range(0, 1), $urandom, 4'hF);
            wb_write(6 + $urandom_range(0, 1), $urandom, 4'hF);
            set_pins(m_pins ^ ({$urandom, $urandom} & VMASK));
            check_pads($sformatf("pin%0d", it));
            read_check(10, $sformatf("pin_is_lo%0d", it));
            read_check(11, $sformatf("pin_is_hi%0d", it));
            read_check(4 + $urandom_range(0, 1), $sformatf("pin_in%0d", it));
            wb_write(10 + $urandom_range(0, 1), $urandom, 4'($urandom_range(0, 15)));
            @(posedge clk); #1;
            check($sformatf("pin_w1c_irq%0d", it), 64'(user_irq), 64'(model_irq()));
        end

        // Reset during a pending write
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = BASE; wdat = 32'hFFFF_FFFF; sel = 4'hF;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstw_ack", 64'(ack), 64'd0);
        check("rstw_out", 64'(io_out), 64'd0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_pins(64'(io_in));
        repeat (5) @(posedge clk);
        #1;
        read_check(0, "rstw_out_rd");
        read_check(10, "rstw_is_lo");
        read_check(11, "rstw_is_hi");
        check_pads("rstw");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
